// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer and microcode decode for a simple 8-bit CPU
module control_sequencer #(
    parameter int CLR_CYCLES = 2,
    parameter bit FAST_FETCH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    input  logic       run,
    input  logic       step,
    output logic       pc_clr_n,
    output logic       pc_lp,
    output logic       pc_cp,
    output logic       pc_ep,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       b_load,
    output logic       out_load,
    output logic       flags_load,
    output logic [2:0] tstate,
    output logic       halted
);
    typedef enum logic [2:0] {
        CLR  = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    logic [2:0] clr_cnt;
    logic       step_q;
    logic       adv;
    logic [2:0] last_t;

    assign adv    = run | (step & ~step_q);
    assign tstate = state;
    assign halted = state == HALT;

    // last active T-state of the current instruction, used to cut the cycle short
    always_comb last_t = (opcode == OP_ADD || opcode == OP_SUB) ? 3'd5 :
                         (opcode == OP_LDA || opcode == OP_STA) ? 3'd4 : 3'd3;

    // sequencer: CLR counts out unconditionally, T-states advance only on adv, HALT is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLR;
            clr_cnt <= 3'd0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            case (state)
                CLR:  if (clr_cnt == 3'(CLR_CYCLES - 1)) state <= T1;
                      else clr_cnt <= clr_cnt + 3'd1;
                T1:   if (adv) state <= T2;
                T2:   if (adv) state <= T3;
                T3:   if (adv) state <= opcode == OP_HLT ? HALT :
                                        (FAST_FETCH && last_t == 3'd3) ? T1 : T4;
                T4:   if (adv) state <= (FAST_FETCH && last_t == 3'd4) ? T1 : T5;
                T5:   if (adv) state <= T1;
                default: state <= state;
            endcase
        end
    end

    // control decode: pulses only on advancing cycles; alu_sub stays decoded so the ALU output is stable
    always_comb begin
        {pc_lp, pc_cp, pc_ep, mar_load, ram_oe, ram_we, ir_load, ir_oe,
         a_load, a_oe, alu_oe, b_load, out_load, flags_load} = '0;
        pc_clr_n = state != CLR;
        alu_sub  = opcode == OP_SUB && (state == T4 || state == T5);
        if (adv) begin
            case (state)
                T1: {pc_ep, mar_load} = 2'b11;
                T2: {ram_oe, ir_load, pc_cp} = 3'b111;
                T3: case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: {ir_oe, mar_load} = 2'b11;
                        OP_LDI: {ir_oe, a_load} = 2'b11;
                        OP_JMP: {ir_oe, pc_lp} = 2'b11;
                        OP_JC:  {ir_oe, pc_lp} = {2{carry_flag}};
                        OP_JZ:  {ir_oe, pc_lp} = {2{zero_flag}};
                        OP_OUT: {a_oe, out_load} = 2'b11;
                        default: ;
                    endcase
                T4: case (opcode)
                        OP_LDA:         {ram_oe, a_load} = 2'b11;
                        OP_ADD, OP_SUB: {ram_oe, b_load} = 2'b11;
                        OP_STA:         {a_oe, ram_we} = 2'b11;
                        default: ;
                    endcase
                T5: if (opcode == OP_ADD || opcode == OP_SUB) {alu_oe, a_load, flags_load} = 3'b111;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: instruction-level reference model plus directed vectors for control_sequencer
module tb_control_sequencer;
    localparam int CLR  = 2;
    localparam bit FAST = 1;
    localparam int LP = 14, CP = 13, EP = 12, MAR = 11, ROE = 10, RWE = 9, IRL = 8, IROE = 7;
    localparam int AL = 6, AOE = 5, ALUOE = 4, SUB = 3, BL = 2, OL = 1, FL = 0;

    logic clk = 0, rst_n = 0;
    logic [3:0] opcode = 0;
    logic carry_flag = 0, zero_flag = 0, run = 1, step = 0;
    logic pc_clr_n, pc_lp, pc_cp, pc_ep, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic a_load, a_oe, alu_oe, alu_sub, b_load, out_load, flags_load, halted;
    logic [2:0] tstate;

    int n_vec = 0, n_err = 0, cyc = 0;
    int mt = 0, mcnt = 0;
    logic mstepq = 0, madv;

    always #5 clk = ~clk;

    control_sequencer #(.CLR_CYCLES(CLR), .FAST_FETCH(FAST)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .run(run), .step(step), .pc_clr_n(pc_clr_n), .pc_lp(pc_lp), .pc_cp(pc_cp), .pc_ep(pc_ep),
        .mar_load(mar_load), .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe),
        .a_load(a_load), .a_oe(a_oe), .alu_oe(alu_oe), .alu_sub(alu_sub), .b_load(b_load),
        .out_load(out_load), .flags_load(flags_load), .tstate(tstate), .halted(halted)
    );

    // number of T-states an instruction actually uses
    function automatic int len(input logic [3:0] op);
        return (op == 4'h2 || op == 4'h3) ? 5 : (op == 4'h1 || op == 4'h4) ? 4 : 3;
    endfunction

    // micro-operation table: control signals asserted by instruction op at T-state t
    function automatic logic [14:0] uc(input logic [3:0] op, input int t, input logic c, input logic z);
        logic [14:0] m;
        m = '0;
        if (t == 1) begin m[EP] = 1; m[MAR] = 1; end
        else if (t == 2) begin m[ROE] = 1; m[IRL] = 1; m[CP] = 1; end
        else if (t == 3) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: begin m[IROE] = 1; m[MAR] = 1; end
                4'h5: begin m[IROE] = 1; m[AL] = 1; end
                4'h6: begin m[IROE] = 1; m[LP] = 1; end
                4'h7: begin m[IROE] = c; m[LP] = c; end
                4'h8: begin m[IROE] = z; m[LP] = z; end
                4'hE: begin m[AOE] = 1; m[OL] = 1; end
                default: ;
            endcase
        end else if (t == 4) begin
            case (op)
                4'h1: begin m[ROE] = 1; m[AL] = 1; end
                4'h2, 4'h3: begin m[ROE] = 1; m[BL] = 1; end
                4'h4: begin m[AOE] = 1; m[RWE] = 1; end
                default: ;
            endcase
        end else if (t == 5 && (op == 4'h2 || op == 4'h3)) begin
            m[ALUOE] = 1; m[AL] = 1; m[FL] = 1;
        end
        m[SUB] = op == 4'h3 && (t == 4 || t == 5);
        return m;
    endfunction

    // reference model of the instruction position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt = 0; mcnt = 0; mstepq = 0;
        end else begin
            madv = run | (step & ~mstepq);
            if (mt == 0) begin
                if (mcnt == CLR - 1) mt = 1; else mcnt++;
            end else if (mt != 7 && madv) begin
                if (mt == 3 && opcode == 4'hF) mt = 7;
                else if (mt >= (FAST ? len(opcode) : 5)) mt = 1;
                else mt++;
            end
            mstepq = step;
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin : cmp
        logic [14:0] ctl;
        logic [19:0] e, g;
        cyc++;
        ctl = (mt >= 1 && mt <= 5) ? uc(opcode, mt, carry_flag, zero_flag) : 15'd0;
        if (!(run | (step & ~mstepq))) ctl = ctl & (15'd1 << SUB);
        e = {mt != 0, ctl, 3'(mt), mt == 7};
        g = {pc_clr_n, pc_lp, pc_cp, pc_ep, mar_load, ram_oe, ram_we, ir_load, ir_oe, a_load, a_oe,
             alu_oe, alu_sub, b_load, out_load, flags_load, tstate, halted};
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL outputs cycle %0d: got %h expected %h (state %0d op %h)", cyc, g, e, mt, opcode);
        end
        n_vec++;
        if (!$onehot0({pc_ep, ram_oe, ir_oe, a_oe, alu_oe})) begin
            n_err++;
            $display("FAIL bus_contention cycle %0d: drivers %b", cyc, {pc_ep, ram_oe, ir_oe, a_oe, alu_oe});
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int t);
        for (int i = 0; i < 40 && mt != t; i++) @(negedge clk);
        n_vec++;
        if (mt != t) begin
            n_err++;
            $display("FAIL wait_state: got %0d expected %0d", mt, t);
        end
    endtask

    logic [3:0] ops [10] = '{4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h8, 4'hE, 4'h0, 4'h9, 4'hC};
    logic       zs  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int changes;
    logic [2:0] prev;

    initial begin
        neg(2);
        lit("rst_tstate", 8'(tstate), 8'd0);
        lit("rst_pc_clr_n", 8'(pc_clr_n), 8'd0);
        @(posedge clk); #1 rst_n = 1;
        neg(1); lit("clr_c1", 8'(pc_clr_n), 8'd0);
        neg(1); lit("clr_c2", 8'(pc_clr_n), 8'd0);
        neg(1); lit("t1_state", 8'(tstate), 8'd1); lit("t1_ctl", 8'({pc_ep, mar_load}), 8'd3);
        opcode = 4'h2;
        neg(1); lit("t2_ctl", 8'({tstate, ram_oe, ir_load, pc_cp}), 8'b010_111);
        neg(1); lit("add_t3", 8'({tstate, ir_oe, mar_load}), 8'b011_11);
        neg(1); lit("add_t4", 8'({ram_oe, b_load, alu_sub}), 8'b110);
        neg(1); lit("add_t5", 8'({alu_oe, a_load, flags_load, alu_sub}), 8'b1110);
        neg(1); lit("add_wrap", 8'(tstate), 8'd1);
        opcode = 4'h3;
        neg(3); lit("sub_t4", 8'({b_load, alu_sub}), 8'b11);
        neg(1); lit("sub_t5", 8'({alu_oe, alu_sub}), 8'b11);
        neg(1); opcode = 4'h7; carry_flag = 0;
        neg(2); lit("jc_nc_t3", 8'({tstate, ir_oe, pc_lp}), 8'b011_00);
        neg(1); lit("jc_nc_wrap", 8'(tstate), 8'd1); carry_flag = 1;
        neg(2); lit("jc_c_t3", 8'({ir_oe, pc_lp}), 8'b11);
        neg(1);
        for (int k = 0; k < 10; k++) begin
            wait_state(1);
            opcode = ops[k]; zero_flag = zs[k]; carry_flag = k[0];
            neg(1);
        end
        wait_state(1);
        opcode = 4'h0; run = 0; changes = 0; prev = tstate;
        for (int r = 0; r < 3; r++) begin
            step = 1;
            for (int i = 0; i < 4; i++) begin neg(1); if (tstate != prev) changes++; prev = tstate; end
            step = 0;
            for (int i = 0; i < 2; i++) begin neg(1); if (tstate != prev) changes++; prev = tstate; end
        end
        lit("step_advances", 8'(changes), 8'd3);
        run = 1;
        wait_state(1);
        opcode = 4'hF;
        wait_state(7);
        lit("halt_state", 8'({tstate, halted}), 8'b111_1);
        for (int i = 0; i < 20; i++) begin run = i[0]; step = i[1]; neg(1); end
        lit("halt_sticky", 8'({tstate, halted}), 8'b111_1);
        #2 rst_n = 0;
        #1 lit("halt_rst", 8'({tstate, pc_clr_n, halted}), 8'd0);
        run = 1; step = 0; opcode = 4'h0;
        @(posedge clk); #1 rst_n = 1;
        wait_state(1);
        opcode = 4'h4;
        wait_state(4);
        lit("sta_t4", 8'({a_oe, ram_we}), 8'b11);
        #1 rst_n = 0;
        #1 lit("sta_rst_async", 8'({ram_we, tstate, pc_clr_n}), 8'd0);
        @(posedge clk); #1 rst_n = 1;
        neg(1); lit("restart_c1", 8'(pc_clr_n), 8'd0);
        neg(1); lit("restart_c2", 8'(pc_clr_n), 8'd0);
        neg(1); lit("restart_t1", 8'(tstate), 8'd1);
        neg(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter CLR_CYCLES, default 2, number of cycles pc_clr_n is held low after rst_n release (range 1-7).
REQ-002 Parameter FAST_FETCH, default 1; 1 = return to T1 after an instruction's last active T-state, 0 = always run T1..T5.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 opcode  in  4  instruction-register upper nibble; stable from T3 to the end of the instruction.
REQ-006 carry_flag, zero_flag  in  1 each  registered ALU flags.
REQ-007 run  in  1  1 = free-run; 0 = single-step mode.
REQ-008 step  in  1  synchronous level; a rising edge advances one T-state when run=0.
REQ-009 pc_clr_n, pc_lp, pc_cp, pc_ep  out  1 each  program counter clear (active-low), load, count, output enable.
REQ-010 mar_load, ram_oe, ram_we, ir_load, ir_oe, a_load, a_oe, alu_oe, alu_sub, b_load, out_load, flags_load  out  1 each  datapath controls, active-high.
REQ-011 tstate  out  3  0=CLR, 1..5=T1..T5, 7=HALT.
REQ-012 halted  out  1  high only in HALT.

Function
REQ-013 States: CLR, T1, T2, T3, T4, T5, HALT; register encoding equals tstate.
REQ-014 adv = run | step_rise; step_rise = step & ~step_q, where step_q is step registered one cycle.
REQ-015 When adv=0, state holds and every control output in REQ-009/010 is 0, except pc_clr_n=1 and alu_sub as decoded.
REQ-016 When adv=1, control outputs equal the decode of the current state, opcode and flags; outputs are combinational from registered state.
REQ-017 T1: pc_ep, mar_load. T2: ram_oe, ir_load, pc_cp.
REQ-018 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; all others decode as NOP.
REQ-019 LDA: T3 ir_oe+mar_load; T4 ram_oe+a_load.
REQ-020 ADD: T3 ir_oe+mar_load; T4 ram_oe+b_load; T5 alu_oe+a_load+flags_load.
REQ-021 SUB: same as ADD, with alu_sub=1 in T4 and T5.
REQ-022 STA: T3 ir_oe+mar_load; T4 a_oe+ram_we.
REQ-023 LDI: T3 ir_oe+a_load. JMP: T3 ir_oe+pc_lp. OUT: T3 a_oe+out_load.
REQ-024 JC/JZ: T3 ir_oe+pc_lp only if carry_flag/zero_flag is 1 in that cycle; otherwise no outputs.
REQ-025 HLT: T3 has no outputs; on adv the next state is HALT.
REQ-026 Transitions on adv: CLR->T1 once its count expires; T1->T2->T3; T5->T1.
REQ-027 With FAST_FETCH=1, the next state after the last active T-state is T1: T3 for NOP/LDI/JMP/JC/JZ/OUT, T4 for LDA/STA, T5 for ADD/SUB.
REQ-028 With FAST_FETCH=0, the sequence T1..T5 always completes.
REQ-029 In HALT: all control outputs inactive, pc_clr_n=1, halted=1; run and step are ignored; exit only via rst_n.
REQ-030 At most one of pc_ep, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle.
REQ-031 Opcode changes after T3 are not tracked; decode uses the live opcode input per REQ-005.

Reset
REQ-032 While rst_n=0: state=CLR, CLR counter=0, step_q=0, pc_clr_n=0, all other control outputs 0, halted=0, tstate=0.
REQ-033 After release, CLR lasts exactly CLR_CYCLES cycles with pc_clr_n=0, regardless of run/step; the next state is T1.
REQ-034 rst_n assertion mid-instruction or in HALT immediately forces the REQ-032 values.

Verification
REQ-035 Reset with run=1, CLR_CYCLES=2 -> pc_clr_n=0 for 2 cycles after release, then tstate 1,2,3 with T1={pc_ep,mar_load}, T2={ram_oe,ir_load,pc_cp}.
REQ-036 opcode=2 (ADD), FAST_FETCH=1 -> T3 mar_load, T4 b_load, T5 alu_oe+a_load+flags_load, then T1; opcode=3 additionally sets alu_sub in T4/T5.
REQ-037 opcode=7 (JC) with carry_flag=0 then 1 -> first instance: no pc_lp in T3, next T1; second instance: ir_oe+pc_lp in T3.
REQ-038 run=0, step held high 4 cycles then low, repeated 3 times -> exactly 3 state advances; controls pulse only in the advancing cycles.
REQ-039 opcode=F -> after T3, tstate=7, halted=1, outputs 0 for 20 cycles despite run/step toggling; rst_n low -> tstate=0, pc_clr_n=0.
REQ-040 rst_n asserted in T4 of STA -> ram_we drops in the same cycle (asynchronously), and the CLR sequence restarts on release.
